maxnet_result_reader: RTL and testbench

- Consumer-side counterpart of the maxnet cellular top.
- Watches the maxnet `done` flag and snapshots the four processing-unit outputs on its rising edge.
- Scans the snapshot serially over 4 cycles and presents the winner (index, value, one-hot), plus convergence status, to a downstream consumer over a valid/ready handshake.
- Sits between the maxnet core and the result sink (display/host interface) in the same clock domain.

---
 rtl/maxnet_result_reader_pkg.sv | 24 ++
 rtl/maxnet_result_reader_if.sv | 40 ++++
 rtl/maxnet_result_reader_scan.sv | 75 +++++++
 rtl/maxnet_result_reader.sv | 143 ++++++++++++++
 tb/tb_maxnet_result_reader.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/maxnet_result_reader_pkg.sv
// Shared types and constants for the maxnet result reader.
// State encoding and index width are common to the top and scan datapath.
package maxnet_result_reader_pkg;

  localparam int WIDTH_DEF = 5;
  localparam int N_PU_DEF  = 4;
  localparam int PU_IDX_W  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    PRESENT = 2'd2
  } state_e;

  function automatic logic [N_PU_DEF-1:0] idx_onehot(
    input logic [PU_IDX_W-1:0] idx
  );
    logic [N_PU_DEF-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/maxnet_result_reader_if.sv
// Result handshake bundle from the reader to the result sink.
// master drives the result fields, slave returns ready.
interface maxnet_result_reader_if
  import maxnet_result_reader_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic                res_valid;
  logic                res_ready;
  logic [PU_IDX_W-1:0] winner_idx;
  logic [WIDTH-1:0]    winner_val;
  logic [N_PU_DEF-1:0] winner_onehot;
  logic [2:0]          nz_count;
  logic                no_winner;
  logic                ambiguous;

  modport master (
    output res_valid,
    input  res_ready,
    output winner_idx,
    output winner_val,
    output winner_onehot,
    output nz_count,
    output no_winner,
    output ambiguous
  );

  modport slave (
    input  res_valid,
    output res_ready,
    input  winner_idx,
    input  winner_val,
    input  winner_onehot,
    input  nz_count,
    input  no_winner,
    input  ambiguous
  );

endinterface

// File: rtl/maxnet_result_reader_scan.sv
// Snapshot registers and serial max/nonzero fold over the PU values.
// fold_* expose the post-step values so the last element lands same edge.
module maxnet_result_reader_scan
  import maxnet_result_reader_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N_PU  = N_PU_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic                       step,
  input  logic [N_PU-1:0][WIDTH-1:0] pu,
  output logic                       last,
  output logic [WIDTH-1:0]           fold_val,
  output logic [PU_IDX_W-1:0]        fold_idx,
  output logic [2:0]                 fold_nz
);

  logic [N_PU-1:0][WIDTH-1:0] snap_q, snap_d;
  logic [PU_IDX_W-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]           max_q, max_d;
  logic [PU_IDX_W-1:0]        idx_q, idx_d;
  logic [2:0]                 nz_q, nz_d;
  logic [WIDTH-1:0]           elem;

  assign elem = snap_q[cnt_q];
  assign last = (cnt_q == PU_IDX_W'(N_PU - 1));

  always_comb begin
    snap_d = snap_q;
    cnt_d  = cnt_q;
    max_d  = max_q;
    idx_d  = idx_q;
    nz_d   = nz_q;
    if (load) begin
      snap_d = pu;
      cnt_d  = '0;
      max_d  = '0;
      idx_d  = '0;
      nz_d   = '0;
    end else if (step) begin
      // strict compare keeps the lowest index on ties
      if (elem > max_q) begin
        max_d = elem;
        idx_d = cnt_q;
      end
      if (elem != '0) begin
        nz_d = nz_q + 3'd1;
      end
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      snap_q <= '0;
      cnt_q  <= '0;
      max_q  <= '0;
      idx_q  <= '0;
      nz_q   <= '0;
    end else begin
      snap_q <= snap_d;
      cnt_q  <= cnt_d;
      max_q  <= max_d;
      idx_q  <= idx_d;
      nz_q   <= nz_d;
    end
  end

  assign fold_val = max_d;
  assign fold_idx = idx_d;
  assign fold_nz  = nz_d;

endmodule

// File: rtl/maxnet_result_reader.sv
// Captures maxnet PU outputs on done rise, scans them and presents
// the winner over a valid/ready handshake.
module maxnet_result_reader
  import maxnet_result_reader_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N_PU  = N_PU_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    done,
  input  logic [WIDTH-1:0]        pu_out1,
  input  logic [WIDTH-1:0]        pu_out2,
  input  logic [WIDTH-1:0]        pu_out3,
  input  logic [WIDTH-1:0]        pu_out4,
  maxnet_result_reader_if.master  res,
  output logic                    busy,
  output logic                    dropped
);

  state_e                     state_q, state_d;
  logic                       done_q;
  logic                       rise;
  logic                       load, step, last;
  logic [N_PU-1:0][WIDTH-1:0] pu_vec;
  logic [WIDTH-1:0]           fold_val;
  logic [PU_IDX_W-1:0]        fold_idx;
  logic [2:0]                 fold_nz;
  logic                       nw;

  logic                valid_q, valid_d;
  logic [PU_IDX_W-1:0] widx_q, widx_d;
  logic [WIDTH-1:0]    wval_q, wval_d;
  logic [N_PU-1:0]     woh_q, woh_d;
  logic [2:0]          nz_q, nz_d;
  logic                nw_q, nw_d;
  logic                amb_q, amb_d;
  logic                busy_q, busy_d;
  logic                drop_q, drop_d;

  assign pu_vec = {pu_out4, pu_out3, pu_out2, pu_out1};
  assign rise   = done && !done_q;
  assign nw     = (fold_nz == 3'd0);

  maxnet_result_reader_scan #(
    .WIDTH (WIDTH),
    .N_PU  (N_PU)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .pu       (pu_vec),
    .last     (last),
    .fold_val (fold_val),
    .fold_idx (fold_idx),
    .fold_nz  (fold_nz)
  );

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    widx_d  = widx_q;
    wval_d  = wval_q;
    woh_d   = woh_q;
    nz_d    = nz_q;
    nw_d    = nw_q;
    amb_d   = amb_q;
    drop_d  = drop_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          load    = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        step = 1'b1;
        if (rise) drop_d = 1'b1;
        if (last) begin
          state_d = PRESENT;
          valid_d = 1'b1;
          nw_d    = nw;
          amb_d   = (fold_nz > 3'd1);
          nz_d    = fold_nz;
          widx_d  = nw ? '0 : fold_idx;
          wval_d  = nw ? '0 : fold_val;
          woh_d   = nw ? '0 : N_PU'(idx_onehot(fold_idx));
        end
      end
      PRESENT: begin
        if (rise) drop_d = 1'b1;
        if (res.res_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      widx_q  <= '0;
      wval_q  <= '0;
      woh_q   <= '0;
      nz_q    <= '0;
      nw_q    <= 1'b0;
      amb_q   <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done;
      valid_q <= valid_d;
      widx_q  <= widx_d;
      wval_q  <= wval_d;
      woh_q   <= woh_d;
      nz_q    <= nz_d;
      nw_q    <= nw_d;
      amb_q   <= amb_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  assign res.res_valid     = valid_q;
  assign res.winner_idx    = widx_q;
  assign res.winner_val    = wval_q;
  assign res.winner_onehot = woh_q;
  assign res.nz_count      = nz_q;
  assign res.no_winner     = nw_q;
  assign res.ambiguous     = amb_q;
  assign busy              = busy_q;
  assign dropped           = drop_q;

endmodule

// File: tb/tb_maxnet_result_reader.sv
// Randomized self-checking bench for maxnet_result_reader.
// Expected results come from a max/count model over the captured values.
module tb_maxnet_result_reader;
  import maxnet_result_reader_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       done;
  logic [4:0] pu [4];
  logic       busy, dropped;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  maxnet_result_reader_if #(.WIDTH(5)) rif ();

  maxnet_result_reader #(.WIDTH(5), .N_PU(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .done    (done),
    .pu_out1 (pu[0]),
    .pu_out2 (pu[1]),
    .pu_out3 (pu[2]),
    .pu_out4 (pu[3]),
    .res     (rif.master),
    .busy    (busy),
    .dropped (dropped)
  );

  typedef logic [4:0] vals_t [4];

  // {idx, val, onehot, nz, no_winner, ambiguous}
  function automatic logic [15:0] model(input vals_t v);
    int mx, idx, nz;
    logic [3:0] oh;
    mx = 0; nz = 0; idx = 0;
    foreach (v[i]) begin
      if (int'(v[i]) > mx) mx = int'(v[i]);
      if (v[i] != 0) nz++;
    end
    for (int i = 3; i >= 0; i--)
      if (int'(v[i]) == mx) idx = i;
    if (nz == 0) idx = 0;
    oh = (nz == 0) ? 4'b0 : 4'(1 << idx);
    return {2'(idx), 5'(mx), oh, 3'(nz), nz == 0, nz > 1};
  endfunction

  function automatic logic [15:0] got();
    return {rif.winner_idx, rif.winner_val, rif.winner_onehot,
            rif.nz_count, rif.no_winner, rif.ambiguous};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // drives one capture and waits for res_valid; lat = edges after capture
  task automatic capture(input vals_t v, input bit hold, output int lat);
    foreach (v[i]) pu[i] = v[i];
    done = 1'b1;
    tick();
    if (!hold) done = 1'b0;
    lat = 0;
    while (!rif.res_valid && lat < 12) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; done = 1'b0; rif.res_ready = 1'b0;
    foreach (pu[i]) pu[i] = '0;
    @(negedge clk);
    tick(); tick();
    total++;
    if ({rif.res_valid, got(), busy, dropped} !== 19'd0) begin
      bad++;
      $display("FAIL reset_state got=%h want=0",
               {rif.res_valid, got(), busy, dropped});
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single(input vals_t v, input string nm);
    int lat;
    logic [15:0] exp;
    exp = model(v);
    rif.res_ready = 1'b1;
    capture(v, 1'b0, lat);
    total++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL %s_latency got=%0d want=4", nm, lat);
    end
    total++;
    if (got() !== exp || busy !== 1'b1) begin
      bad++;
      $display("FAIL %s_result got=%h busy=%b want=%h busy=1",
               nm, got(), busy, exp);
    end
    tick();
    total++;
    if (rif.res_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle valid=%b busy=%b want 0 0",
               nm, rif.res_valid, busy);
    end
    rif.res_ready = 1'b0;
  endtask

  task automatic test_stall();
    vals_t v;
    int lat;
    logic [15:0] exp;
    v = '{5'd0, 5'd5, 5'd0, 5'd0};
    exp = model(v);
    rif.res_ready = 1'b0;
    capture(v, 1'b0, lat);
    total++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL stall_latency got=%0d want=4", lat);
    end
    for (int c = 0; c < 10; c++) begin
      foreach (pu[i]) pu[i] = 5'($urandom_range(0, 31));
      tick();
      total++;
      if (rif.res_valid !== 1'b1 || got() !== exp) begin
        bad++;
        $display("FAIL stall_hold cyc=%0d valid=%b got=%h want=%h",
                 c, rif.res_valid, got(), exp);
      end
    end
    rif.res_ready = 1'b1;
    tick();
    total++;
    if (rif.res_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_release valid=%b want=0", rif.res_valid);
    end
    rif.res_ready = 1'b0;
  endtask

  task automatic test_drop();
    vals_t v;
    int lat, nres;
    logic [15:0] exp;
    v = '{5'd3, 5'd17, 5'd0, 5'd17};
    exp = model(v);
    rif.res_ready = 1'b0;
    foreach (pu[i]) pu[i] = v[i];
    done = 1'b1;
    tick();
    done = 1'b0;
    foreach (pu[i]) pu[i] = 5'd31;
    tick();
    done = 1'b1;
    lat = 2;
    tick();
    done = 1'b0;
    while (!rif.res_valid && lat < 12) begin
      tick();
      lat++;
    end
    total++;
    if (lat !== 4 || got() !== exp) begin
      bad++;
      $display("FAIL drop_result lat=%0d got=%h want lat=4 %h",
               lat, got(), exp);
    end
    total++;
    if (dropped !== 1'b1) begin
      bad++;
      $display("FAIL drop_flag got=%b want=1", dropped);
    end
    rif.res_ready = 1'b1;
    tick();
    // done held high for 20 cycles must yield one result only
    nres = 0;
    foreach (pu[i]) pu[i] = 5'(i + 1);
    done = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (rif.res_valid) nres++;
    end
    done = 1'b0;
    total++;
    if (nres !== 1) begin
      bad++;
      $display("FAIL hold_done results=%0d want=1", nres);
    end
    rif.res_ready = 1'b0;
    tick();
  endtask

  task automatic test_mid_reset();
    vals_t v;
    int lat;
    v = '{5'd1, 5'd2, 5'd30, 5'd4};
    foreach (pu[i]) pu[i] = v[i];
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    total++;
    if ({rif.res_valid, got(), busy, dropped} !== 19'd0) begin
      bad++;
      $display("FAIL mid_reset got=%h want=0",
               {rif.res_valid, got(), busy, dropped});
    end
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      total++;
      if (rif.res_valid !== 1'b0) begin
        bad++;
        $display("FAIL abort_no_result cyc=%0d valid=1 want=0", c);
      end
    end
    v = '{5'd9, 5'd0, 5'd0, 5'd0};
    rif.res_ready = 1'b1;
    capture(v, 1'b0, lat);
    total++;
    if (lat !== 4 || got() !== model(v) || dropped !== 1'b0) begin
      bad++;
      $display("FAIL post_reset lat=%0d got=%h drop=%b want 4 %h 0",
               lat, got(), dropped, model(v));
    end
    tick();
    rif.res_ready = 1'b0;
  endtask

  task automatic test_random();
    vals_t v;
    int lat, wait_n;
    logic [15:0] exp;
    for (int n = 0; n < 30; n++) begin
      foreach (v[i])
        v[i] = ($urandom_range(0, 2) == 0) ? 5'd0 :
               (n % 2 == 1) ? 5'($urandom_range(29, 31)) :
                              5'($urandom_range(1, 31));
      exp = model(v);
      rif.res_ready = 1'b0;
      capture(v, 1'b0, lat);
      total++;
      if (lat !== 4 || got() !== exp) begin
        bad++;
        $display("FAIL rand_%0d lat=%0d got=%h want lat=4 %h",
                 n, lat, got(), exp);
      end
      wait_n = $urandom_range(0, 3);
      repeat (wait_n) tick();
      rif.res_ready = 1'b1;
      tick();
      rif.res_ready = 1'b0;
      total++;
      if (rif.res_valid !== 1'b0) begin
        bad++;
        $display("FAIL rand_hs_%0d valid=1 want=0", n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single('{5'd0, 5'd0, 5'd13, 5'd0}, "single");
    test_single('{5'd0, 5'd0, 5'd0, 5'd0}, "zeros");
    test_single('{5'd7, 5'd9, 5'd9, 5'd3}, "tie");
    test_stall();
    test_drop();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
